// File: rtl/rx_core_param.sv
// rx_core_param: parametrised UART receive core with show-ahead FIFO.
// Synchronises Rx_i, validates the start bit, samples each bit mid-cell on AcqSig_i ticks,
// checks parity and stop bits, stores {frameErr, parityErr, data} per character and
// pulses p_FrameEnd_o after a configurable idle gap.
// Optional feature macro: RX_MAJORITY_VOTE_EN (2-of-3 vote around the mid-bit tick).
module rx_core_param #(
    parameter int unsigned OVS        = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               p_Enable_i,
    input  logic               AcqSig_i,
    input  logic               Rx_i,
    input  logic [1:0]         DataLen_i,
    input  logic               p_ParityEnable_i,
    input  logic               ParityMethod_i,
    input  logic               StopBits_i,
    input  logic               p_BigEnd_i,
    input  logic [15:0]        RxTimeOutSet_i,
    input  logic               n_Rd_i,
    input  logic               n_Clr_i,
    output logic [7:0]         Data_o,
    output logic               p_HeadParityErr_o,
    output logic               p_HeadFrameErr_o,
    output logic               p_Empty_o,
    output logic               p_Full_o,
    output logic               p_Over_o,
    output logic [FIFO_AW:0]   RxFifoLevel_o,
    output logic               p_FrameEnd_o,
    output logic [7:0]         ParityErrorNum_o
);
    localparam int unsigned CntW   = (OVS > 2) ? $clog2(OVS) : 1;
    localparam int unsigned LevelW = FIFO_AW + 1;
`ifdef RX_MAJORITY_VOTE_EN
    // Decision is taken on the last of the three voting ticks.
    localparam int unsigned SampleIdx = OVS / 2 + 1;
`else
    localparam int unsigned SampleIdx = OVS / 2;
`endif

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} stateT;

    stateT            state;
    logic             rxMeta, rxSync, rxPrev;
    logic [CntW-1:0]  tickCnt, tickNext;
    logic [2:0]       bitCnt, lastBit, dataPos;
    logic [7:0]       shiftReg;
    logic             parErr, frmErr, stopCnt;
    logic [1:0]       cfgLen;
    logic             cfgParEn, cfgParOdd, cfgStop2, cfgBigEnd;
    logic             wrReq;
    logic [9:0]       wrEntry;
    logic             sampleNow, bitVal, startDet, charDone;
    logic [15:0]      idleCnt;
    logic             armed;
    logic [9:0]       mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wrPtr, rdPtr;
    logic [LevelW-1:0]  count;
    logic             doRd, doWr, overQ;
    logic [7:0]       errCnt;

    // Two-flop synchroniser, preset to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= Rx_i;
            rxSync <= rxMeta;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic vote0, vote1;
    // Capture the two samples preceding the decision tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            vote0 <= 1'b1;
            vote1 <= 1'b1;
        end else if (AcqSig_i) begin
            if (tickNext == CntW'(SampleIdx - 2)) vote0 <= rxSync;
            if (tickNext == CntW'(SampleIdx - 1)) vote1 <= rxSync;
        end
    end
`endif

    // Tick position, bit decision and character bookkeeping.
    always_comb begin
        tickNext  = (tickCnt == CntW'(OVS - 1)) ? '0 : tickCnt + CntW'(1);
        sampleNow = AcqSig_i && (state != StIdle) && (tickNext == CntW'(SampleIdx));
`ifdef RX_MAJORITY_VOTE_EN
        bitVal    = (vote0 & vote1) | (vote0 & rxSync) | (vote1 & rxSync);
`else
        bitVal    = rxSync;
`endif
        // Edge only counts if the previous tick saw the line high, so a held break never restarts.
        startDet  = AcqSig_i && p_Enable_i && (state == StIdle) && rxPrev && !rxSync;
        charDone  = sampleNow && (state == StStop) && (stopCnt == cfgStop2);
        lastBit   = 3'd4 + {1'b0, cfgLen};
        dataPos   = cfgBigEnd ? (lastBit - bitCnt) : bitCnt;
    end

    // Receive FSM; emits a registered write request with the finished entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            rxPrev    <= 1'b1;
            tickCnt   <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            parErr    <= 1'b0;
            frmErr    <= 1'b0;
            stopCnt   <= 1'b0;
            cfgLen    <= '0;
            cfgParEn  <= 1'b0;
            cfgParOdd <= 1'b0;
            cfgStop2  <= 1'b0;
            cfgBigEnd <= 1'b0;
            wrReq     <= 1'b0;
            wrEntry   <= '0;
        end else begin
            wrReq <= 1'b0;
            if (AcqSig_i) rxPrev <= rxSync;
            if (!p_Enable_i) begin
                state <= StIdle;
            end else if (startDet) begin
                state     <= StStart;
                tickCnt   <= '0;
                bitCnt    <= '0;
                shiftReg  <= '0;
                parErr    <= 1'b0;
                frmErr    <= 1'b0;
                stopCnt   <= 1'b0;
                cfgLen    <= DataLen_i;
                cfgParEn  <= p_ParityEnable_i;
                cfgParOdd <= ParityMethod_i;
                cfgStop2  <= StopBits_i;
                cfgBigEnd <= p_BigEnd_i;
            end else if (AcqSig_i && state != StIdle) begin
                tickCnt <= tickNext;
                if (sampleNow) begin
                    unique case (state)
                        StStart: state <= bitVal ? StIdle : StData;
                        StData: begin
                            shiftReg[dataPos] <= bitVal;
                            bitCnt <= bitCnt + 3'd1;
                            if (bitCnt == lastBit) state <= cfgParEn ? StParity : StStop;
                        end
                        StParity: begin
                            parErr <= (bitVal != ((^shiftReg) ^ cfgParOdd));
                            state  <= StStop;
                        end
                        StStop: begin
                            if (!bitVal) frmErr <= 1'b1;
                            stopCnt <= 1'b1;
                            if (charDone) begin
                                state   <= StIdle;
                                wrReq   <= 1'b1;
                                wrEntry <= {frmErr | !bitVal, parErr, shiftReg};
                            end
                        end
                        default: state <= StIdle;
                    endcase
                end
            end
        end
    end

    // Idle-gap counter: armed by a finished character, fires once per gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            idleCnt      <= '0;
            armed        <= 1'b0;
            p_FrameEnd_o <= 1'b0;
        end else begin
            p_FrameEnd_o <= 1'b0;
            if (!p_Enable_i) begin
                armed <= 1'b0;
            end else if (startDet) begin
                idleCnt <= '0;
            end else if (charDone) begin
                armed   <= 1'b1;
                idleCnt <= '0;
            end else if (AcqSig_i && state == StIdle && armed) begin
                idleCnt <= idleCnt + 16'd1;
                if (RxTimeOutSet_i != 16'd0 && (idleCnt + 16'd1) == RxTimeOutSet_i) begin
                    p_FrameEnd_o <= 1'b1;
                    armed        <= 1'b0;
                end
            end
        end
    end

    // Reads on an empty FIFO are ignored; a write into a full FIFO only succeeds with a read.
    always_comb begin
        doRd = !n_Rd_i && (count != '0);
        doWr = wrReq && ((count != LevelW'(FIFO_DEPTH)) || doRd);
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (n_Clr_i && doWr) mem[wrPtr] <= wrEntry;
    end

    // FIFO pointers, level, sticky overflow and parity error count; clear wins.
    always_ff @(posedge clk) begin
        if (rst || !n_Clr_i) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            overQ  <= 1'b0;
            errCnt <= '0;
        end else begin
            if (doWr) wrPtr <= wrPtr + FIFO_AW'(1);
            if (doRd) rdPtr <= rdPtr + FIFO_AW'(1);
            if (doWr && !doRd) count <= count + LevelW'(1);
            else if (!doWr && doRd) count <= count - LevelW'(1);
            if (wrReq && !doWr) overQ <= 1'b1;
            if (wrReq && wrEntry[8] && errCnt != 8'hFF) errCnt <= errCnt + 8'd1;
        end
    end

    // Registered show-ahead head and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            Data_o            <= '0;
            p_HeadParityErr_o <= 1'b0;
            p_HeadFrameErr_o  <= 1'b0;
            p_Empty_o         <= 1'b1;
            p_Full_o          <= 1'b0;
            RxFifoLevel_o     <= '0;
        end else begin
            p_Empty_o     <= (count == '0);
            p_Full_o      <= (count == LevelW'(FIFO_DEPTH));
            RxFifoLevel_o <= count;
            if (count != '0) begin
                Data_o            <= mem[rdPtr][7:0];
                p_HeadParityErr_o <= mem[rdPtr][8];
                p_HeadFrameErr_o  <= mem[rdPtr][9];
            end else begin
                Data_o            <= '0;
                p_HeadParityErr_o <= 1'b0;
                p_HeadFrameErr_o  <= 1'b0;
            end
        end
    end

    assign p_Over_o         = overQ;
    assign ParityErrorNum_o = errCnt;

endmodule
